iob_native_split: RTL



---
 rtl/iob_native_split.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/iob_native_split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iob_native_split                                               |
// | Brief    : Routes a PicoRV32-style native memory port to one of N_CH IOb |
// |            master channels. It generates write acks, waits for read      |
// |            rvalid, bounds every access with a timeout and returns error  |
// |            responses for decode misses and timeouts.                     |
// | Revision : 1.0 - initial parametrised release                            |
// +--------------------------------------------------------------------------+
module iob_native_split #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                N_CH        = 3,
  parameter int                SEL_W       = 1,
  parameter int                SPLIT_INSTR = 1,
  parameter int                TIMEOUT_W   = 8,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cke_i,
  input  logic                     cpu_valid_i,
  input  logic                     cpu_instr_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [DATA_W-1:0]        cpu_wdata_i,
  input  logic [DATA_W/8-1:0]      cpu_wstrb_i,
  output logic                     cpu_ready_o,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic [N_CH-1:0]          iob_avalid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic [N_CH*DATA_W-1:0]   iob_rdata_i,
  input  logic [N_CH-1:0]          iob_rvalid_i,
  input  logic [N_CH-1:0]          iob_ready_i,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  input  logic                     err_clr_i
);

  localparam int STRB_W = DATA_W / 8;
  // One extra bit so "MSBs + SPLIT_INSTR" never wraps back onto a valid channel.
  localparam int CH_W   = SEL_W + 1;
  // Last counter value before the limit: reaching 2^TIMEOUT_W-1 ends the access.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = ~(TIMEOUT_W'(1));

  localparam logic [1:0] CODE_MISS    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RDWAIT = 3'd2,
    S_ACK    = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic [CH_W-1:0]       dec_ch;
  logic                  dec_miss;
  logic [N_CH-1:0]       sel;
  logic [DATA_W-1:0]     rd_sel;
  logic                  ready_hit;
  logic                  rvalid_hit;

  // Channel decode of the incoming request (fetches pinned to ch0 when split).
  always_comb begin
    dec_ch = '0;
    if (!((SPLIT_INSTR != 0) && cpu_instr_i)) begin
      dec_ch = CH_W'(cpu_addr_i[ADDR_W-1 -: SEL_W]) + CH_W'(SPLIT_INSTR);
    end
    dec_miss = (int'(dec_ch) >= N_CH);
  end

  // One-hot of the latched channel; compared as integers so no channel aliases.
  for (genvar k = 0; k < N_CH; k++) begin : g_sel
    assign sel[k] = (int'(ch_q) == k);
  end

  // Pick the read data slice of the latched channel.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel[k]) rd_sel = iob_rdata_i[k*DATA_W +: DATA_W];
    end
  end

  assign ready_hit  = |(iob_ready_i & sel);
  assign rvalid_hit = |(iob_rvalid_i & sel);

  // Next-state and datapath updates; error set takes priority over clear.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    code_d  = code_q;
    if (err_clr_i) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end
    case (state_q)
      S_IDLE: begin
        if (cpu_valid_i) begin
          ch_d    = dec_ch;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          wstrb_d = cpu_wstrb_i;
          cnt_d   = '0;
          rdata_d = '0;
          if (dec_miss) begin
            state_d = S_ERR;
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            code_d  = CODE_MISS;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (ready_hit) begin
          state_d = (|wstrb_q) ? S_ACK : S_RDWAIT;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          code_d  = CODE_TIMEOUT;
        end
      end
      S_RDWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rvalid_hit) begin
          state_d = S_ACK;
          rdata_d = rd_sel;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          code_d  = CODE_TIMEOUT;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, frozen while cke_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else if (cke_i) begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign cpu_ready_o  = (state_q == S_ACK) || (state_q == S_ERR);
  assign cpu_rdata_o  = rdata_q;
  assign iob_avalid_o = (state_q == S_REQ) ? sel : '0;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;

endmodule
`default_nettype wire
